// File: rtl/data_bus_bridge.sv
// data_bus_bridge
//   Turns the core's single-cycle combinational data bus into a registered
//   valid/ready request plus response-valid transaction toward data memory or
//   a peripheral fabric. The core is stalled until the transaction completes.
//   A response timeout aborts the transaction and reports bus_error.
//
// Parameters
//   DATA_W            data word width (32 for this core)
//   TIMEOUT_CYCLES    cycles from request issue to response before abort (>= 2)
//   ERROR_READ_VALUE  word returned on bus_read_data for a timed-out read
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   bus_address          byte address from the core
//   bus_write_data       lane-shifted write data
//   bus_byte_enable      lane enables
//   bus_read_enable      read request
//   bus_write_enable     write request (wins over a simultaneous read)
//   bus_read_data        raw read word, held until the next read completes
//   bus_stall            core must hold its bus inputs and not advance
//   bus_error            one-cycle pulse when a transaction timed out
//   mem_req_valid/ready  request handshake toward memory
//   mem_we               1 = write, 0 = read
//   mem_addr             word-aligned request address
//   mem_wdata/mem_wstrb  latched write data and byte enables
//   mem_rsp_valid        read response or write acknowledge
//   mem_rsp_data         read response word
module data_bus_bridge #(
  parameter int                DATA_W           = 32,
  parameter int                TIMEOUT_CYCLES   = 255,
  parameter logic [DATA_W-1:0] ERROR_READ_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         bus_address,
  input  logic [DATA_W-1:0]   bus_write_data,
  input  logic [DATA_W/8-1:0] bus_byte_enable,
  input  logic                bus_read_enable,
  input  logic                bus_write_enable,
  output logic [DATA_W-1:0]   bus_read_data,
  output logic                bus_stall,
  output logic                bus_error,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tmo_cnt;

  logic has_req;
  logic skip_mem;
  logic busy;
  logic tmo_hit;
  logic rsp_hit;

  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

  // Request decode, next state and combinational outputs
  always_comb begin
    has_req   = bus_read_enable | bus_write_enable;
    // A write with no lanes enabled has nothing to send to memory.
    skip_mem  = bus_write_enable && (bus_byte_enable == '0);
    busy      = (state == REQ) || (state == WAIT_RSP);
    tmo_hit   = busy && (tmo_cnt == TMO_LIMIT);
    rsp_hit   = (state == WAIT_RSP) && mem_rsp_valid;
    state_nxt = state;

    unique case (state)
      IDLE: begin
        if (has_req) begin
          state_nxt = skip_mem ? DONE : REQ;
        end
      end
      REQ: begin
        // mem_rsp_valid is not looked at here: memory answers only after acceptance.
        if (tmo_hit) begin
          state_nxt = DONE;
        end else if (mem_req_ready) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response on the limit cycle still completes normally.
        if (rsp_hit || tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    bus_stall     = ((state == IDLE) && has_req) || busy;
    mem_req_valid = (state == REQ);
  end

  // Registered state, request fields, timeout and read-back word
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      bus_error     <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      bus_read_data <= '0;
    end else begin
      state     <= state_nxt;
      bus_error <= tmo_hit && !rsp_hit;

      if ((state == IDLE) && has_req) begin
        mem_we    <= bus_write_enable;
        mem_addr  <= word_align(bus_address);
        mem_wdata <= bus_write_data;
        mem_wstrb <= bus_byte_enable;
      end

      // Cleared in IDLE so it starts from zero on entry to REQ; the state
      // leaves REQ/WAIT_RSP on the limit, so it never wraps.
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (rsp_hit && !mem_we) begin
        bus_read_data <= mem_rsp_data;
      end else if (tmo_hit && !mem_we) begin
        bus_read_data <= ERROR_READ_VALUE;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge
//   Directed and randomized transactions against data_bus_bridge. The bench
//   plays the memory side with a chosen ready delay and response delay per
//   transaction and predicts stall length, request-valid length, error pulse
//   and read-back word from the transaction-level timing rules.
module tb_data_bus_bridge;

  localparam int          T    = 8;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;
  localparam int          NEVER = 99;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;
  logic        bus_stall;
  logic        bus_error;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata;

  data_bus_bridge #(
    .DATA_W           (32),
    .TIMEOUT_CYCLES   (T),
    .ERROR_READ_VALUE (ERRV)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_byte_enable  (bus_byte_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_read_data    (bus_read_data),
    .bus_stall        (bus_stall),
    .bus_error        (bus_error),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_we"},    32'(mem_we),        32'd0);
    chk({tag, "_addr"},  mem_addr,           32'd0);
    chk({tag, "_wdata"}, mem_wdata,          32'd0);
    chk({tag, "_wstrb"}, 32'(mem_wstrb),     32'd0);
    chk({tag, "_rdata"}, bus_read_data,      32'd0);
    chk({tag, "_error"}, 32'(bus_error),     32'd0);
    chk({tag, "_stall"}, 32'(bus_stall),     32'd0);
  endtask

  // op: 0 read, 1 write, 2 read+write (write wins), 3 write with no lanes.
  // rd: valid cycles before ready; wd: cycles after acceptance before the
  // response. NEVER means the event does not happen.
  task automatic run_txn(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be_in, input int rd, input int wd,
                         input logic [31:0] rsp_word);
    logic [3:0] be;
    logic       is_wr, nz, timeo, v_seen, rdy_seen, rs_seen, accepted, rsp_sent, done;
    int         vcnt, wcnt, stall_n, err_n, cyc, total, exp_stall, exp_valid;

    is_wr     = (op != 0);
    be        = (op == 3) ? 4'b0000 : be_in;
    nz        = !(is_wr && (be == 4'b0000));
    total     = rd + 1 + wd;
    timeo     = nz && (total > T);
    exp_stall = !nz ? 1 : (timeo ? T + 2 : total + 2);
    exp_valid = !nz ? 0 : ((timeo && rd >= T) ? T + 1 : rd + 1);

    bus_address      = addr;
    bus_write_data   = wdata;
    bus_byte_enable  = be;
    bus_read_enable  = (op == 0) || (op == 2);
    bus_write_enable = is_wr;

    vcnt = 0; wcnt = 0; stall_n = 0; err_n = 0; cyc = 0;
    accepted = 1'b0; rsp_sent = 1'b0; done = 1'b0;

    while (!done && cyc < 60) begin
      mem_req_ready = mem_req_valid && (vcnt == rd);
      mem_rsp_valid = accepted && !rsp_sent && (wcnt == wd);
      mem_rsp_data  = mem_rsp_valid ? rsp_word : $urandom();
      if (mem_req_valid) begin
        chk("req_addr", mem_addr, {addr[31:2], 2'b00});
        chk("req_we", 32'(mem_we), 32'(is_wr));
        if (is_wr) begin
          chk("req_wdata", mem_wdata, wdata);
          chk("req_wstrb", 32'(mem_wstrb), 32'(be));
        end
      end
      @(negedge clock);
      v_seen   = mem_req_valid;
      rdy_seen = mem_req_ready;
      rs_seen  = mem_rsp_valid;
      if (bus_error) err_n++;
      if (bus_stall) begin
        stall_n++;
      end else begin
        done = 1'b1;
        if (op == 0) exp_rdata = timeo ? ERRV : rsp_word;
        chk("done_error", 32'(bus_error), 32'(timeo));
        chk("done_rdata", bus_read_data, exp_rdata);
      end
      tick();
      if (v_seen) vcnt++;
      if (accepted) wcnt++;
      if (v_seen && rdy_seen) begin
        accepted = 1'b1;
        wcnt     = 0;
      end
      if (rs_seen) rsp_sent = 1'b1;
      cyc++;
    end

    if (!done) chk("txn_done", 32'd0, 32'd1);
    chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
    chk("valid_cycles", 32'(vcnt), 32'(exp_valid));
    chk("error_pulses", 32'(err_n), timeo ? 32'd1 : 32'd0);

    // Idle cycle after the transaction; a late response follows an abort.
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    mem_req_ready    = 1'b0;
    mem_rsp_valid    = timeo;
    mem_rsp_data     = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("idle_stall", 32'(bus_stall), 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    chk("idle_rdata", bus_read_data, exp_rdata);
    chk("idle_error", 32'(bus_error), 32'd0);
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    bus_address      = '0;
    bus_write_data   = '0;
    bus_byte_enable  = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    mem_req_ready    = 1'b0;
    mem_rsp_valid    = 1'b0;
    mem_rsp_data     = '0;
    exp_rdata        = '0;

    tick();
    tick();
    @(negedge clock);
    check_reset_vals("reset");
    tick();
    reset = 1'b0;

    // Read with earliest ready and response
    run_txn(0, 32'h0000_1006, 32'h0, 4'hF, 0, 0, 32'hA1B2C3D4);
    // Write held off by ready for 5 cycles
    run_txn(1, 32'h0000_0020, 32'h00EF_0000, 4'b0100, 5, 0, 32'h5555_5555);
    // Read that never gets a response
    run_txn(0, 32'h0000_0300, 32'h0, 4'hF, 0, NEVER, 32'h0);
    // Response exactly on the limit cycle completes normally
    run_txn(0, 32'h0000_0304, 32'h0, 4'hF, 0, 7, 32'h1357_9BDF);
    // Response one cycle past the limit is too late
    run_txn(0, 32'h0000_0308, 32'h0, 4'hF, 0, 8, 32'h2468_ACE0);
    // Write with no lanes enabled
    run_txn(3, 32'h0000_0044, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0);
    // Read and write together: one write
    run_txn(2, 32'h0000_004A, 32'h0000_BEEF, 4'b0011, 1, 1, 32'h7777_7777);
    // Write never accepted
    run_txn(1, 32'h0000_0050, 32'h1234_5678, 4'b1111, NEVER, 0, 32'h0);

    // Reset while waiting for a response
    bus_address     = 32'h0000_0040;
    bus_read_enable = 1'b1;
    tick();
    mem_req_ready = 1'b1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd1);
    tick();
    mem_req_ready = 1'b0;
    chk("rst_wait_valid", 32'(mem_req_valid), 32'd0);
    reset = 1'b1;
    tick();
    reset           = 1'b0;
    bus_read_enable = 1'b0;
    mem_rsp_valid   = 1'b1;
    mem_rsp_data    = 32'h1234_5678;
    @(negedge clock);
    check_reset_vals("midrst");
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    chk("late_rsp_rdata", bus_read_data, 32'd0);
    chk("late_rsp_stall", 32'(bus_stall), 32'd0);
    tick();
    exp_rdata = '0;

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      int          op, rd, wd;
      logic [31:0] a, d, r;
      logic [3:0]  be;
      op = int'($urandom_range(0, 3));
      rd = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
      wd = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
      a  = $urandom();
      d  = $urandom();
      r  = $urandom();
      be = 4'($urandom_range(1, 15));
      run_txn(op, a, d, be, rd, wd, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
